uart_tx_fifo_drain: RTL and testbench

//  UART transmitter: pops bytes from a 16-deep byte FIFO (registered read, data valid 1 clk after rd_en)
//  and serialises each one onto the tx line as 8N1 (or 8E1/8O1 with parity). Transmit-side partner of
//  the RX path; sits between the TX byte FIFO and the pad.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo_drain_if.sv | 30 +++
 rtl/uart_tx_fifo_drain_baud_gen.sv | 41 ++++
 rtl/uart_tx_fifo_drain.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//  Shared UART definitions for the TX drain path (and its RX partner):
//  frame geometry constants and the transmitter state encoding.
//  No ports.
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE_LVL  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain_if
//  Read-side handshake between the TX byte FIFO and the UART transmitter.
//   fifo_avail : FIFO holds at least one byte
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en : one-cycle pop strobe
//  Modports:
//   master : transmitter side (issues pops, consumes data)
//   slave  : FIFO side (answers pops)
// ----------------------------------------------------------------------------
interface uart_tx_fifo_drain_if;
   import uart_pkg::*;

   logic                      fifo_avail;
   logic [UART_DATA_BITS-1:0] fifo_data;
   logic                      fifo_rd_en;

   modport master (
      input  fifo_avail,
      input  fifo_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_avail,
      output fifo_data,
      input  fifo_rd_en
   );

endinterface

// File: rtl/uart_tx_fifo_drain_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_gen
//  Bit-period counter shared by the UART TX and RX paths. Counts
//  0..CLKS_PER_BIT-1 while enabled and wraps; restart forces it back to 0 so
//  every frame starts on a fresh bit boundary.
//  Ports:
//   clk, reset : clock, asynchronous active-low reset
//   restart    : synchronous clear (wins over en)
//   en         : count enable
//   cnt        : current position inside the bit period
//   bit_end    : high on the last clk of a bit period while enabled
// ----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter  int CLKS_PER_BIT = 16,
   localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             bit_end
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   // NOTE: state flops use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign bit_end = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain
//  UART transmitter that drains a registered-read byte FIFO and serialises
//  each byte as 8N1, or 8E1/8O1 when the parity option is built in.
//  Frame: start(0), 8 data bits LSB first, [parity], STOP_BITS stop bits (1).
//  Build option: define UART_TX_PARITY_EN to insert the parity bit
//  (even when PARITY_ODD=0, odd when PARITY_ODD=1).
//  Ports:
//   clk     : clock, all state on rising edge
//   reset   : asynchronous active-low reset
//   fifo    : FIFO read handshake (master side)
//   tx      : serial line, idle high, driven from a flop
//   busy    : high from FETCH through the end of the last stop bit
//   tx_done : one-clk pulse on the last clk of the final stop bit
// ----------------------------------------------------------------------------
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   uart_tx_fifo_drain_if.master        fifo,
   output logic                        tx,
   output logic                        busy,
   output logic                        tx_done
);

   localparam int               CNT_W       = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [2:0]       LAST_DATA   = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0]       LAST_STOP   = 3'(STOP_BITS - 1);

   tx_state_e                 state;
   logic [UART_DATA_BITS-1:0] shift_reg;
   logic [2:0]                bit_cnt;     // data bit index, then stop bit index
   logic [CNT_W-1:0]          baud_cnt;
   logic                      bit_end;
   logic                      baud_restart;
   logic                      baud_en;
   logic                      last_stop;

`ifdef UART_TX_PARITY_EN
   logic parity_bit;                       // captured with the byte in LOAD
`else
   logic unused_parity_cfg;
   assign unused_parity_cfg = 1'(PARITY_ODD);
`endif

   assign baud_restart = (state == LOAD);
   assign baud_en      = (state inside {START, DATA, PARITY, STOP});
   assign last_stop    = (state == STOP) && (bit_cnt == LAST_STOP);

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .clk     (clk),
      .reset   (reset),
      .restart (baud_restart),
      .en      (baud_en),
      .cnt     (baud_cnt),
      .bit_end (bit_end)
   );

   // tx, busy, fifo_rd_en and tx_done are all registered: each is assigned
   // the value it must hold in the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         tx              <= UART_IDLE_LVL;
         busy            <= 1'b0;
         tx_done         <= 1'b0;
         fifo.fifo_rd_en <= 1'b0;
         shift_reg       <= '0;
         bit_cnt         <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit      <= 1'b0;
`endif
      end else begin
         // Strobes default low so they can only ever last one clk.
         fifo.fifo_rd_en <= 1'b0;
         tx_done         <= 1'b0;

         case (state)
            IDLE: begin
               tx   <= UART_IDLE_LVL;
               busy <= 1'b0;
               if (fifo.fifo_avail) begin
                  fifo.fifo_rd_en <= 1'b1;
                  busy            <= 1'b1;
                  state           <= FETCH;
               end
            end

            // Pop is in flight; the FIFO presents data after this edge.
            FETCH: state <= LOAD;

            LOAD: begin
               shift_reg  <= fifo.fifo_data;
               bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
               parity_bit <= (^fifo.fifo_data) ^ 1'(PARITY_ODD);
`endif
               tx         <= 1'b0;
               state      <= START;
            end

            START: begin
               if (bit_end) begin
                  tx    <= shift_reg[0];
                  state <= DATA;
               end
            end

            DATA: begin
               if (bit_end) begin
                  shift_reg <= shift_reg >> 1;
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     tx      <= parity_bit;
                     state   <= PARITY;
`else
                     tx      <= UART_IDLE_LVL;
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= shift_reg[1];   // next LSB after the shift
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  tx    <= UART_IDLE_LVL;
                  state <= STOP;
               end
            end
`endif

            STOP: begin
               // One-clk lookahead so the registered pulse lands on the
               // final clk of the last stop bit.
               if (last_stop && (baud_cnt == CNT_PRELAST)) begin
                  tx_done <= 1'b1;
               end
               if (bit_end) begin
                  if (last_stop) begin
                     bit_cnt <= '0;
                     if (fifo.fifo_avail) begin
                        fifo.fifo_rd_en <= 1'b1;
                        state           <= FETCH;
                     end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            default: begin
               tx    <= UART_IDLE_LVL;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//  Two transmitters (CLKS_PER_BIT=4): channel 0 with one stop bit and even
//  parity, channel 1 with two stop bits and odd parity (parity bit only when
//  UART_TX_PARITY_EN is defined). Each drains its own registered-read FIFO
//  model. A per-channel line decoder rebuilds every frame from the tx line and
//  compares it with the frame implied by the next byte written to that FIFO.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;
   import uart_pkg::*;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   uart_tx_fifo_drain_if bus_a ();
   uart_tx_fifo_drain_if bus_b ();

   logic [1:0] tx_w, busy_w, done_w, avail_w, rd_w;

   uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
      .clk     (clk),
      .reset   (reset),
      .fifo    (bus_a),
      .tx      (tx_w[0]),
      .busy    (busy_w[0]),
      .tx_done (done_w[0])
   );

   uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
      .clk     (clk),
      .reset   (reset),
      .fifo    (bus_b),
      .tx      (tx_w[1]),
      .busy    (busy_w[1]),
      .tx_done (done_w[1])
   );

   // ---------------- FIFO models (registered read) ----------------
   logic [7:0] mem [2][256];
   int         wr_ptr [2];
   int         rd_ptr [2];
   int         pop_total [2];
   int         underflow [2];
   bit [1:0]   gate;

   assign bus_a.fifo_avail = gate[0] && (wr_ptr[0] != rd_ptr[0]);
   assign bus_b.fifo_avail = gate[1] && (wr_ptr[1] != rd_ptr[1]);
   assign avail_w = {bus_b.fifo_avail, bus_a.fifo_avail};
   assign rd_w    = {bus_b.fifo_rd_en, bus_a.fifo_rd_en};

   always @(posedge clk) begin
      if (bus_a.fifo_rd_en) begin
         if (rd_ptr[0] == wr_ptr[0]) underflow[0] <= underflow[0] + 1;
         bus_a.fifo_data <= mem[0][rd_ptr[0] % 256];
         rd_ptr[0]       <= rd_ptr[0] + 1;
      end
      if (bus_b.fifo_rd_en) begin
         if (rd_ptr[1] == wr_ptr[1]) underflow[1] <= underflow[1] + 1;
         bus_b.fifo_data <= mem[1][rd_ptr[1] % 256];
         rd_ptr[1]       <= rd_ptr[1] + 1;
      end
   end

   always @(negedge clk) begin
      if (bus_a.fifo_rd_en) pop_total[0] <= pop_total[0] + 1;
      if (bus_b.fifo_rd_en) pop_total[1] <= pop_total[1] + 1;
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic string tagc(input string s, input int ch);
      return $sformatf("ch%0d_%s", ch, s);
   endfunction

   function automatic int stop_of(input int ch);
      return (ch == 0) ? 1 : 2;
   endfunction

   task automatic push(input int ch, input logic [7:0] b);
      mem[ch][wr_ptr[ch] % 256] = b;
      wr_ptr[ch]++;
   endtask

   // ---------------- line decoder / scoreboard ----------------
   int sb_ptr [2];
   int frames [2];

   task automatic monitor(input int ch);
      int         nbits, clks, gap, done_n, done_pos, last_pop;
      bit         avail_at_end, aborted, glitch;
      logic [11:0] obs, expv;
      logic [7:0]  b;
      nbits = 1 + UART_DATA_BITS + PB + stop_of(ch);
      clks  = nbits * CPB;
      gap = 0; avail_at_end = 0; last_pop = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin avail_at_end = 0; gap = 0; continue; end
         if (tx_w[ch] !== 1'b0) begin gap++; continue; end
         // start bit seen: this negedge is clk 0 of the frame
         if (avail_at_end) check(tagc("gap", ch), gap, 2);
         check(tagc("pops", ch), pop_total[ch] - last_pop, 1);
         last_pop = pop_total[ch];
         b = mem[ch][sb_ptr[ch] % 256];
         sb_ptr[ch]++;
         expv = '0;
         for (int i = 0; i < UART_DATA_BITS; i++) expv[1+i] = b[i];
         if (PB == 1) expv[1+UART_DATA_BITS] = (^b) ^ (ch == 1);
         for (int k = 1 + UART_DATA_BITS + PB; k < nbits; k++) expv[k] = 1'b1;
         obs = '0; glitch = 0; done_n = 0; done_pos = -1; aborted = 0;
         for (int c = 0; c < clks; c++) begin
            if (c != 0) @(negedge clk);
            if (!reset) begin aborted = 1; break; end
            if (c % CPB == 0) obs[c/CPB] = tx_w[ch];
            else if (tx_w[ch] !== obs[c/CPB]) glitch = 1;
            if (busy_w[ch] !== 1'b1) glitch = 1;
            if (done_w[ch] === 1'b1) begin done_n++; done_pos = c; end
         end
         gap = 0;
         if (aborted) begin avail_at_end = 0; continue; end
         check(tagc("frame", ch), obs, expv);
         check(tagc("steady", ch), glitch, 0);
         check(tagc("done_cnt", ch), done_n, 1);
         check(tagc("done_pos", ch), done_pos, clks - 1);
         frames[ch]++;
         avail_at_end = avail_w[ch];
      end
   endtask

   initial begin
      fork
         monitor(0);
         monitor(1);
      join_none
   end

   task automatic wait_idle(input int max_cycles);
      bit ok = 0;
      for (int k = 0; k < max_cycles; k++) begin
         @(negedge clk);
         if (wr_ptr[0] == rd_ptr[0] && wr_ptr[1] == rd_ptr[1] && busy_w == 2'b00) begin
            ok = 1;
            break;
         end
      end
      check("drain_in_time", ok, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int bad_rd [2];
      int bad_tx [2];
      int bad_busy [2];
      int n_burst, n_wait, tx_hi_bad, busy_bad;
      bit seen;

      // reset state
      reset = 1'b0;
      gate  = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      for (int ch = 0; ch < 2; ch++) begin
         check(tagc("rst_tx", ch), tx_w[ch], 1);
         check(tagc("rst_busy", ch), busy_w[ch], 0);
         check(tagc("rst_done", ch), done_w[ch], 0);
         check(tagc("rst_rd_en", ch), rd_w[ch], 0);
      end
      reset = 1'b1;

      // empty FIFO for 100 clks
      for (int ch = 0; ch < 2; ch++) begin bad_rd[ch] = 0; bad_tx[ch] = 0; bad_busy[ch] = 0; end
      repeat (100) begin
         @(negedge clk);
         for (int ch = 0; ch < 2; ch++) begin
            if (rd_w[ch] !== 1'b0) bad_rd[ch]++;
            if (tx_w[ch] !== 1'b1) bad_tx[ch]++;
            if (busy_w[ch] !== 1'b0) bad_busy[ch]++;
         end
      end
      for (int ch = 0; ch < 2; ch++) begin
         check(tagc("empty_rd_en", ch), bad_rd[ch], 0);
         check(tagc("empty_tx_low", ch), bad_tx[ch], 0);
         check(tagc("empty_busy", ch), bad_busy[ch], 0);
      end

      // single byte 0x55
      @(posedge clk); #1;
      push(0, 8'h55);
      wait_idle(300);

      // back-to-back 0xA3, 0x0F preloaded; busy must not drop between frames
      gate[0] = 1'b0;
      push(0, 8'hA3);
      push(0, 8'h0F);
      @(posedge clk); #1;
      gate[0] = 1'b1;
      busy_bad = 0;
      seen = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (busy_w[0]) seen = 1;
         if (seen && rd_ptr[0] != wr_ptr[0] && !busy_w[0]) busy_bad++;
         if (seen && rd_ptr[0] == wr_ptr[0] && !busy_w[0]) break;
      end
      check("b2b_busy_gap", busy_bad, 0);
      check("b2b_pops", rd_ptr[0], 3);
      wait_idle(300);

      // two stop bits, 0xFF; then 0x07 on both channels (parity cases)
      @(posedge clk); #1;
      push(1, 8'hFF);
      wait_idle(300);
      @(posedge clk); #1;
      push(0, 8'h07);
      push(1, 8'h07);
      wait_idle(300);

      // randomized bursts with fifo_avail flicker
      for (int it = 0; it < 40; it++) begin
         @(posedge clk); #1;
         for (int ch = 0; ch < 2; ch++) begin
            n_burst = $urandom_range(0, 3);
            for (int j = 0; j < n_burst; j++) push(ch, 8'($urandom));
         end
         n_wait = $urandom_range(5, 60);
         for (int k = 0; k < n_wait; k++) begin
            @(posedge clk); #1;
            gate[0] = ($urandom_range(0, 3) != 0);
            gate[1] = ($urandom_range(0, 3) != 0);
         end
      end
      gate = 2'b11;
      wait_idle(5000);

      // reset in the middle of the data bits
      @(posedge clk); #1;
      push(0, 8'h3C);
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (tx_w[0] === 1'b0) begin seen = 1; break; end
      end
      check("rst_mid_start_seen", seen, 1);
      repeat (14) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("rst_mid_tx", tx_w[0], 1);
      check("rst_mid_busy", busy_w[0], 0);
      check("rst_mid_rd_en", rd_w[0], 0);
      check("rst_mid_done", done_w[0], 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      tx_hi_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) tx_hi_bad++;
      end
      check("rst_mid_quiet", tx_hi_bad, 0);

      // recovery after reset
      @(posedge clk); #1;
      push(0, 8'h81);
      wait_idle(300);

      // totals: every byte decoded in order, one frame lost to the reset
      check("ch0_frames", frames[0], wr_ptr[0] - 1);
      check("ch1_frames", frames[1], wr_ptr[1]);
      check("ch0_sb_ptr", sb_ptr[0], wr_ptr[0]);
      check("ch1_sb_ptr", sb_ptr[1], wr_ptr[1]);
      check("ch0_underflow", underflow[0], 0);
      check("ch1_underflow", underflow[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
